// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle MIPS main control: opcodes, ALUOp codes,
// FSM state encodings and the datapath mux select codes.
package controle_multiciclo_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // funct value that turns an R-type into JR
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // ALUOp codes understood by the ALU control decoder
    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_BEQ   = 4'b0001;
    localparam logic [3:0] ALUOP_BNE   = 4'b0010;
    localparam logic [3:0] ALUOP_SLT   = 4'b0011;
    localparam logic [3:0] ALUOP_SLTU  = 4'b0100;
    localparam logic [3:0] ALUOP_AND   = 4'b0101;
    localparam logic [3:0] ALUOP_OR    = 4'b0110;
    localparam logic [3:0] ALUOP_XOR   = 4'b0111;
    localparam logic [3:0] ALUOP_LUI   = 4'b1000;
    localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

    // FSM states; encodings 13..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        WB_R      = 4'd3,
        EXEC_I    = 4'd4,
        WB_I      = 4'd5,
        MEM_ADDR  = 4'd6,
        MEM_READ  = 4'd7,
        MEM_WB    = 4'd8,
        MEM_WRITE = 4'd9,
        BRANCH    = 4'd10,
        JUMP      = 4'd11,
        JR        = 4'd12
    } state_t;

    // reg_dst select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // mem_to_reg select
    localparam logic [1:0] WBSRC_ALUOUT = 2'b00;
    localparam logic [1:0] WBSRC_MDR    = 2'b01;
    localparam logic [1:0] WBSRC_PC     = 2'b10;

    // alu_src_b select
    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // pc_source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // True for the ALU-immediate opcodes handled by EXEC_I
    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || ((op >= OP_SLTI) && (op <= OP_LUI));
    endfunction

endpackage

// File: rtl/controle_multiciclo_decod_aluop_imm.sv
// Maps an ALU-immediate opcode to its ALUOp and immediate extension mode.
module controle_multiciclo_decod_aluop_imm
    import controle_multiciclo_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] aluop,
    output logic       ext_zero
);

    // Logical ops and SLTIU zero-extend; arithmetic ops and LUI sign-extend
    always_comb begin
        aluop    = ALUOP_ADD;
        ext_zero = 1'b0;
        case (opcode)
            OP_ADDI:  begin aluop = ALUOP_ADD;  ext_zero = 1'b0; end
            OP_SLTI:  begin aluop = ALUOP_SLT;  ext_zero = 1'b0; end
            OP_SLTIU: begin aluop = ALUOP_SLTU; ext_zero = 1'b1; end
            OP_ANDI:  begin aluop = ALUOP_AND;  ext_zero = 1'b1; end
            OP_ORI:   begin aluop = ALUOP_OR;   ext_zero = 1'b1; end
            OP_XORI:  begin aluop = ALUOP_XOR;  ext_zero = 1'b1; end
            OP_LUI:   begin aluop = ALUOP_LUI;  ext_zero = 1'b0; end
            default:  begin aluop = ALUOP_ADD;  ext_zero = 1'b0; end
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control FSM: sequences fetch, decode, execute, memory and
// writeback and drives every datapath enable and mux select.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               i_or_d,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               ext_zero,
    output logic [1:0]         pc_source,
    output logic [3:0]         ALUOp,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] estado
);

    state_t     state;
    state_t     state_next;
    logic [3:0] imm_aluop;
    logic       imm_ext_zero;
    logic       is_beq;
    logic       is_bne;

    controle_multiciclo_decod_aluop_imm u_decod_aluop_imm (
        .opcode   (opcode),
        .aluop    (imm_aluop),
        .ext_zero (imm_ext_zero)
    );

    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);

    // State register; reset abandons whatever instruction was in flight
    always_ff @(posedge clock) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next state and state-decoded outputs; reset forces every output low
    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = WBSRC_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_zero   = 1'b0;
        pc_source  = PCSRC_ALU;
        ALUOp      = ALUOP_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        estado     = STATE_W'(state);

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = SRCB_IMMSH;
                if (opcode == OP_RTYPE) begin
                    state_next = (funct == FUNCT_JR) ? JR : EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = MEM_ADDR;
                end else if (is_beq || is_bne) begin
                    state_next = BRANCH;
                end else if (opcode == OP_J || opcode == OP_JAL) begin
                    state_next = JUMP;
                end else if (is_imm_op(opcode)) begin
                    state_next = EXEC_I;
                end else begin
                    illegal_op = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                ALUOp      = ALUOP_RTYPE;
                state_next = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = WBSRC_ALUOUT;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ALUOp      = imm_aluop;
                ext_zero   = imm_ext_zero;
                state_next = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = WBSRC_ALUOUT;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = WBSRC_MDR;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                pc_source  = PCSRC_ALUOUT;
                ALUOp      = is_bne ? ALUOP_BNE : ALUOP_BEQ;
                pc_write   = (is_beq & zero) | (is_bne & ~zero);
                instr_done = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = WBSRC_PC;
                end
                state_next = FETCH;
            end
            JR: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_RS;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            default: begin
                illegal_op = 1'b1;
                state_next = FETCH;
            end
        endcase

        if (reset) begin
            state_next = FETCH;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            ext_zero   = 1'b0;
            pc_source  = 2'b00;
            ALUOp      = 4'b0000;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            estado     = '0;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: an instruction-level model plans the
// expected output vector of every cycle and a single compare process checks them.
module tb_controle_multiciclo;
    import controle_multiciclo_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic       alu_src_a, ext_zero, instr_done, illegal_op;
    logic [3:0] ALUOp;
    logic [3:0] estado;

    typedef struct packed {
        logic       pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_source;
        logic [3:0] aluop;
        logic       instr_done, illegal_op;
        logic [3:0] estado;
    } ov_t;

    int    checks = 0;
    int    errors = 0;
    ov_t   expq[$];
    string tagq[$];
    string curName;
    logic [5:0] curOp, curFn;
    logic  curZ;
    int    cyc, rstAt;
    bit    aborted;

    controle_multiciclo #(.STATE_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
        .pc_source(pc_source), .ALUOp(ALUOp), .instr_done(instr_done),
        .illegal_op(illegal_op), .estado(estado)
    );

    always #5 clock = ~clock;

    // Compare process: one planned vector per cycle, sampled on the falling edge
    always @(negedge clock) begin
        if (expq.size() > 0) checkOutput(expq.pop_front(), tagq.pop_front());
    end

    task automatic checkOutput(input ov_t e, input string tag);
        ov_t a;
        a = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
             mem_to_reg, alu_src_a, alu_src_b, ext_zero, pc_source, ALUOp,
             instr_done, illegal_op, estado};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, a, e);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy, input logic rst);
        @(posedge clock);
        #1;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        reset     = rst;
    endtask

    function automatic ov_t blank(input state_t st);
        ov_t b;
        b = '0;
        b.estado = st;
        return b;
    endfunction

    function automatic logic dc();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legalOp(input logic [5:0] op);
        case (op)
            6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13,
            6'd14, 6'd15, 6'd35, 6'd43: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ALU-immediate table: ALUOp and whether the immediate is zero-extended
    task automatic immTable(input logic [5:0] op, output logic [3:0] a, output logic z);
        case (op)
            6'b001000: begin a = 4'b0000; z = 1'b0; end
            6'b001010: begin a = 4'b0011; z = 1'b0; end
            6'b001011: begin a = 4'b0100; z = 1'b1; end
            6'b001100: begin a = 4'b0101; z = 1'b1; end
            6'b001101: begin a = 4'b0110; z = 1'b1; end
            6'b001110: begin a = 4'b0111; z = 1'b1; end
            default:   begin a = 4'b1000; z = 1'b0; end
        endcase
    endtask

    // One planned cycle; the cycle numbered rstAt gets reset instead and ends the instruction
    task automatic cycle(input ov_t e, input logic rdy);
        if (aborted) return;
        cyc++;
        if (cyc == rstAt) begin
            applyStimulus(curOp, curFn, curZ, 1'b1, 1'b1);
            expq.push_back('0);
            aborted = 1'b1;
        end else begin
            applyStimulus(curOp, curFn, curZ, rdy, 1'b0);
            expq.push_back(e);
        end
        tagq.push_back($sformatf("%s#%0d", curName, cyc));
    endtask

    task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fw, input int mw, input int rs,
                            input int expCyc);
        ov_t e;
        logic [3:0] ia;
        logic iz;
        curName = name; curOp = op; curFn = fn; curZ = z;
        cyc = 0; rstAt = rs; aborted = 1'b0;
        for (int w = 0; w <= fw; w++) begin
            e = blank(FETCH);
            e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            e.pc_write = (w == fw); e.ir_write = (w == fw);
            cycle(e, w == fw);
        end
        e = blank(DECODE);
        e.alu_src_b = 2'b11;
        if (!legalOp(op)) begin
            e.illegal_op = 1'b1;
            cycle(e, dc());
        end else begin
            cycle(e, dc());
            if (op == 6'b000000 && fn == 6'b001000) begin
                e = blank(JR); e.pc_write = 1'b1; e.pc_source = 2'b11; e.instr_done = 1'b1;
                cycle(e, dc());
            end else if (op == 6'b000000) begin
                e = blank(EXEC_R); e.alu_src_a = 1'b1; e.aluop = 4'b1111;
                cycle(e, dc());
                e = blank(WB_R); e.reg_write = 1'b1; e.reg_dst = 2'b01; e.instr_done = 1'b1;
                cycle(e, dc());
            end else if (op == 6'b100011 || op == 6'b101011) begin
                e = blank(MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cycle(e, dc());
                for (int w = 0; w <= mw; w++) begin
                    if (op == 6'b100011) e = blank(MEM_READ);
                    else begin e = blank(MEM_WRITE); e.mem_write = 1'b1; e.instr_done = (w == mw); end
                    e.mem_read = (op == 6'b100011);
                    e.i_or_d = 1'b1;
                    cycle(e, w == mw);
                end
                if (op == 6'b100011) begin
                    e = blank(MEM_WB); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.instr_done = 1'b1;
                    cycle(e, dc());
                end
            end else if (op == 6'b000100 || op == 6'b000101) begin
                e = blank(BRANCH); e.alu_src_a = 1'b1; e.pc_source = 2'b01; e.instr_done = 1'b1;
                e.aluop = (op == 6'b000100) ? 4'b0001 : 4'b0010;
                e.pc_write = (op == 6'b000100) ? z : !z;
                cycle(e, dc());
            end else if (op == 6'b000010 || op == 6'b000011) begin
                e = blank(JUMP); e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
                if (op == 6'b000011) begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
                cycle(e, dc());
            end else begin
                immTable(op, ia, iz);
                e = blank(EXEC_I); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                e.aluop = ia; e.ext_zero = iz;
                cycle(e, dc());
                e = blank(WB_I); e.reg_write = 1'b1; e.instr_done = 1'b1;
                cycle(e, dc());
            end
        end
        checks++;
        if (cyc != expCyc) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, cyc, expCyc);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1);
            expq.push_back('0);
            tagq.push_back($sformatf("reset#%0d", i));
        end
        //        name     opcode     funct      z  fw mw  rst lat
        runInstr("ADD",   6'b000000, 6'b100000, 0, 0, 0, -1, 4);
        runInstr("ADDw",  6'b000000, 6'b100010, 1, 1, 0, -1, 5);
        runInstr("LW",    6'b100011, 6'b010101, 0, 0, 2, -1, 7);
        runInstr("SW",    6'b101011, 6'b000000, 0, 0, 1, -1, 5);
        runInstr("BEQz1", 6'b000100, 6'b000000, 1, 0, 0, -1, 3);
        runInstr("BEQz0", 6'b000100, 6'b000000, 0, 0, 0, -1, 3);
        runInstr("BNEz1", 6'b000101, 6'b000000, 1, 0, 0, -1, 3);
        runInstr("BNEz0", 6'b000101, 6'b000000, 0, 0, 0, -1, 3);
        runInstr("ORI",   6'b001101, 6'b001000, 0, 0, 0, -1, 4);
        runInstr("ADDI",  6'b001000, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("SLTI",  6'b001010, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("SLTIU", 6'b001011, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("ANDI",  6'b001100, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("XORI",  6'b001110, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("LUI",   6'b001111, 6'b000000, 0, 0, 0, -1, 4);
        runInstr("J",     6'b000010, 6'b000000, 0, 0, 0, -1, 3);
        runInstr("JAL",   6'b000011, 6'b001000, 0, 0, 0, -1, 3);
        runInstr("JR",    6'b000000, 6'b001000, 0, 0, 0, -1, 3);
        runInstr("ILL3F", 6'b111111, 6'b000000, 0, 0, 0, -1, 2);
        runInstr("ILL09", 6'b001001, 6'b000000, 0, 0, 0, -1, 2);
        runInstr("SWrst", 6'b101011, 6'b000000, 0, 0, 0, 4, 4);
        runInstr("ADD2",  6'b000000, 6'b100100, 0, 0, 0, -1, 4);
        @(negedge clock);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
